// File: rtl/pim_pkg.sv
// Shared definitions for the PIM conv sequencer: FSM state encoding and the
// signed saturating arithmetic used by the channel reduction tree.
package pim_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_REDUCE,
    ST_OUT
  } pim_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Operands arrive sign-extended to 32 bits; the result is clamped to an ow-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int ow);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (ow - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (ow - 1));
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/pim_sat_add_tree.sv
// Registered pairwise saturating reduction of N signed OW-bit values; each
// level clamps its own sums, latency clog2(N) cycles (combinational for N=1).
module pim_sat_add_tree
  import pim_pkg::*;
#(
  parameter int N  = 6,
  parameter int OW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N*OW-1:0] in_data,
  output logic            out_valid,
  output logic [OW-1:0]   out_data
);

  localparam int LVL = clog2(N);

  generate
    if (LVL == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data[OW-1:0];
    end else begin : g_pipe
      logic [OW-1:0]  lvl_q [LVL][N];
      logic [OW-1:0]  lvl_d [LVL][N];
      logic [LVL-1:0] vld_q;

      // cur has one spare zero slot so an odd tail pair never indexes past the end
      always_comb begin
        logic [OW-1:0] cur [N+1];
        int            n_src;
        for (int i = 0; i < N; i++) cur[i] = in_data[i*OW +: OW];
        cur[N] = '0;
        n_src  = N;
        for (int l = 0; l < LVL; l++) begin
          for (int i = 0; i < N; i++) lvl_d[l][i] = '0;
          for (int i = 0; i < (N + 1) / 2; i++) begin
            if (2 * i + 1 < n_src)
              lvl_d[l][i] = OW'(sat_add(32'(signed'(cur[2*i])), 32'(signed'(cur[2*i+1])), OW));
            else if (2 * i < n_src)
              lvl_d[l][i] = cur[2*i];
          end
          for (int i = 0; i < N; i++) cur[i] = lvl_q[l][i];
          n_src = (n_src + 1) / 2;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int l = 0; l < LVL; l++)
            for (int i = 0; i < N; i++) lvl_q[l][i] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          for (int l = 1; l < LVL; l++) vld_q[l] <= vld_q[l-1];
          lvl_q <= lvl_d;
        end
      end

      assign out_valid = vld_q[LVL-1];
      assign out_data  = lvl_q[LVL-1][0];
    end
  endgenerate

endmodule

// File: rtl/conv_pim_seq.sv
// Sliding KxK window builder and PIM macro sequencer; collects per-channel
// macro results and returns one saturated channel sum per window.
//  state  | meaning
//  FILL   | accepting rows; window issues once K rows of the frame are present
//  ISSUE  | one-cycle mac_start, clear the done mask
//  WAIT   | capture per-channel results as their done pulses arrive
//  REDUCE | adder tree in flight
//  OUT    | conv_value held until out_ready
module conv_pim_seq
  import pim_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 6,
  parameter int ADDR_WIDTH  = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [CHANNEL*KERNEL_SIZE*BIT_WIDTH-1:0]            in_row,
  input  logic                                                frame_start,
  input  logic [ADDR_WIDTH-1:0]                               bank_sel,
  output logic                                                mac_start,
  output logic [CHANNEL*KERNEL_SIZE*KERNEL_SIZE*BIT_WIDTH-1:0] mac_window,
  output logic [ADDR_WIDTH-1:0]                               mac_addr,
  input  logic [CHANNEL-1:0]                                  mac_done,
  input  logic [CHANNEL*OUT_WIDTH-1:0]                        mac_result,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [OUT_WIDTH-1:0]                                conv_value
);

  localparam int K     = KERNEL_SIZE;
  localparam int ROW_W = KERNEL_SIZE * BIT_WIDTH;
  localparam int RCW   = clog2(KERNEL_SIZE + 1);
  localparam logic [RCW-1:0] ROW_FULL = RCW'(KERNEL_SIZE);

  pim_state_e state_q, state_d;
  logic [CHANNEL-1:0][K-1:0][ROW_W-1:0] win_q, win_d;
  logic [CHANNEL-1:0][ROW_W-1:0]        row_in;
  logic [CHANNEL-1:0][OUT_WIDTH-1:0]    res_q, res_d;
  logic [CHANNEL-1:0]                   mask_q, mask_d;
  logic [RCW-1:0]                       row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic                                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]                 conv_q, conv_d;
  logic                                 tree_in_valid;
  logic                                 tree_out_valid;
  logic [OUT_WIDTH-1:0]                 tree_out;

  assign row_in = in_row;

  // Kept apart from the FSM so the N=1 combinational tree path cannot form a loop through one block
  always_comb begin
    mask_d = mask_q;
    res_d  = res_q;
    if (state_q == ST_ISSUE) begin
      mask_d = '0;
    end else if (state_q == ST_WAIT) begin
      for (int c = 0; c < CHANNEL; c++) begin
        if (mac_done[c] && !mask_q[c]) begin
          mask_d[c] = 1'b1;
          res_d[c]  = mac_result[c*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  assign tree_in_valid = (state_q == ST_WAIT) && (&mask_d);

  pim_sat_add_tree #(.N(CHANNEL), .OW(OUT_WIDTH)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tree_in_valid),
    .in_data  (res_d),
    .out_valid(tree_out_valid),
    .out_data (tree_out)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    row_cnt_d   = row_cnt_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    conv_d      = conv_q;
    if (tree_out_valid) begin
      out_valid_d = 1'b1;
      conv_d      = tree_out;
    end
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          for (int c = 0; c < CHANNEL; c++) begin
            for (int r = 0; r < K - 1; r++) win_d[c][r] = win_q[c][r+1];
            win_d[c][K-1] = row_in[c];
          end
          if (frame_start)                row_cnt_d = RCW'(1);
          else if (row_cnt_q != ROW_FULL) row_cnt_d = row_cnt_q + RCW'(1);
          if (row_cnt_d == ROW_FULL) begin
            addr_d  = bank_sel;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (&mask_d) state_d = tree_out_valid ? ST_OUT : ST_REDUCE;
      end
      ST_REDUCE: begin
        if (tree_out_valid) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      win_q       <= '0;
      res_q       <= '0;
      mask_q      <= '0;
      row_cnt_q   <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      conv_q      <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      res_q       <= res_d;
      mask_q      <= mask_d;
      row_cnt_q   <= row_cnt_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      conv_q      <= conv_d;
    end
  end

  assign in_ready   = (state_q == ST_FILL);
  assign mac_start  = (state_q == ST_ISSUE);
  assign mac_window = win_q;
  assign mac_addr   = addr_q;
  assign out_valid  = out_valid_q;
  assign conv_value = conv_q;

endmodule

// File: tb/tb_conv_pim_seq.sv
// Directed bench for conv_pim_seq: expected conv values are queued when macro
// results are driven and popped when the DUT presents its output.
module tb_conv_pim_seq;

  localparam int CH  = 6;
  localparam int K   = 5;
  localparam int BW  = 8;
  localparam int OW  = 8;
  localparam int AW  = 1;
  localparam int LVL = 3;
  localparam int RW  = K * BW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [CH*RW-1:0]      in_row = '0;
  logic                  frame_start = 1'b0;
  logic [AW-1:0]         bank_sel = '0;
  logic                  mac_start;
  logic [CH*K*RW-1:0]    mac_window;
  logic [AW-1:0]         mac_addr;
  logic [CH-1:0]         mac_done = '0;
  logic [CH*OW-1:0]      mac_result = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [OW-1:0]         conv_value;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  conv_pim_seq #(
    .BIT_WIDTH(BW), .OUT_WIDTH(OW), .KERNEL_SIZE(K), .CHANNEL(CH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .frame_start(frame_start), .bank_sel(bank_sel), .mac_start(mac_start),
    .mac_window(mac_window), .mac_addr(mac_addr), .mac_done(mac_done),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
    .conv_value(conv_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [CH*RW-1:0] mk_row(input int seed);
    logic [CH*RW-1:0] r;
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < K; j++)
        r[(c*K+j)*BW +: BW] = 8'(seed * 37 + c * 11 + j * 3 + 1);
    return r;
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int model(input int r[CH]);
    int v[CH];
    int n, m;
    v = r;
    n = CH;
    while (n > 1) begin
      m = (n + 1) / 2;
      for (int i = 0; i < m; i++) begin
        if (2 * i + 1 < n) v[i] = clamp8(v[2*i] + v[2*i+1]);
        else               v[i] = v[2*i];
      end
      n = m;
    end
    return v[0];
  endfunction

  function automatic logic [RW-1:0] win_row(input int c, input int r);
    logic [CH*K*RW-1:0] w;
    w = mac_window;
    return w[(c*K+r)*RW +: RW];
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the row is accepted.
  task automatic send_row(input logic [CH*RW-1:0] d, input logic fs, input logic [AW-1:0] b);
    int w;
    w = 0;
    in_row = d; frame_start = fs; bank_sel = b; in_valid = 1'b1;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("row_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_done(input logic [CH-1:0] m, input int r[CH]);
    mac_done = m;
    for (int c = 0; c < CH; c++) mac_result[c*OW +: OW] = 8'(r[c]);
    @(posedge clk);
    @(negedge clk);
    mac_done = '0;
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int lat;
    int e;
    logic [OW-1:0] e8;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    e8 = e[OW-1:0];
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_value"}, 64'(conv_value), 64'(e8));
      chk({tag, "_hold_inready"}, 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    chk({tag, "_value"}, 64'(conv_value), 64'(e8));
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'(0));
    chk({tag, "_refill"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [CH*RW-1:0] rowv [16];
    int r[CH];
    int r_ign[CH];
    int quiet;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mac_start", 64'(mac_start), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mac_addr", 64'(mac_addr), 64'(0));
    chk("rst_conv", 64'(conv_value), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) rowv[i] = mk_row(i);

    // first fill, bank 1 on the completing row
    for (int i = 0; i < 5; i++) begin
      send_row(rowv[i], 1'(i == 0), AW'(i == 4));
      chk("fill_mac_start", 64'(mac_start), 64'(i == 4));
    end
    chk("issue_in_ready", 64'(in_ready), 64'(0));
    chk("win_ch0_r0", 64'(win_row(0, 0)), 64'(rowv[0][0 +: RW]));
    chk("win_ch0_r4", 64'(win_row(0, 4)), 64'(rowv[4][0 +: RW]));
    chk("win_ch5_r2", 64'(win_row(5, 2)), 64'(rowv[2][5*RW +: RW]));
    chk("mac_addr_b1", 64'(mac_addr), 64'(1));
    @(negedge clk);
    chk("mac_start_pulse", 64'(mac_start), 64'(0));

    // staggered done, with a repeated ch0 done that must be ignored
    r = '{1, 2, 3, 4, 5, 6};
    r_ign = '{99, 99, 99, 99, 99, 99};
    exp_q.push_back(21);
    pulse_done(6'b101001, r);
    pulse_done(6'b000001, r_ign);
    @(negedge clk);
    chk("partial_no_out", 64'(out_valid), 64'(0));
    pulse_done(6'b010110, r);
    collect("stagger", LVL + 1, 4);

    // sliding window: one row re-issues without refill
    send_row(rowv[5], 1'b0, 1'b0);
    chk("slide_mac_start", 64'(mac_start), 64'(1));
    chk("slide_ch0_r0", 64'(win_row(0, 0)), 64'(rowv[1][0 +: RW]));
    chk("slide_ch3_r4", 64'(win_row(3, 4)), 64'(rowv[5][3*RW +: RW]));
    chk("slide_mac_addr", 64'(mac_addr), 64'(0));
    @(negedge clk);
    r = '{100, 100, 100, 100, 100, 100};
    exp_q.push_back(127);
    pulse_done('1, r);
    collect("sat_pos", LVL + 1, 0);

    send_row(rowv[6], 1'b0, 1'b1);
    chk("slide2_mac_start", 64'(mac_start), 64'(1));
    @(negedge clk);
    r = '{-100, -100, -100, -100, -100, -100};
    exp_q.push_back(-128);
    pulse_done('1, r);
    collect("sat_neg", LVL + 1, 0);

    send_row(rowv[7], 1'b0, 1'b0);
    chk("slide3_mac_start", 64'(mac_start), 64'(1));
    @(negedge clk);
    r = '{127, 127, -128, -128, 0, 0};
    exp_q.push_back(-1);
    pulse_done('1, r);
    collect("sat_mix", LVL + 1, 0);

    // frame restart on the third row; out_ready high meanwhile has no effect
    out_ready = 1'b1;
    send_row(rowv[8], 1'b1, 1'b0);
    chk("fs_row0", 64'(mac_start), 64'(0));
    send_row(rowv[9], 1'b0, 1'b0);
    chk("fs_row1", 64'(mac_start), 64'(0));
    send_row(rowv[10], 1'b1, 1'b0);
    chk("fs_restart", 64'(mac_start), 64'(0));
    for (int i = 11; i < 15; i++) begin
      send_row(rowv[i], 1'b0, AW'(i == 14));
      chk("fs_refill", 64'(mac_start), 64'(i == 14));
    end
    chk("fs_no_out", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    chk("fs_win_r0", 64'(win_row(2, 0)), 64'(rowv[10][2*RW +: RW]));
    chk("fs_mac_addr", 64'(mac_addr), 64'(1));
    @(negedge clk);
    for (int c = 0; c < CH; c++) r[c] = int'($urandom_range(0, 255)) - 128;
    exp_q.push_back(model(r));
    pulse_done(6'b110010, r);
    pulse_done(6'b001101, r);
    collect("rand", LVL + 1, 2);

    // reset mid-window, then a late done pulse must produce nothing
    send_row(rowv[15], 1'b0, 1'b1);
    chk("pre_rst_issue", 64'(mac_start), 64'(1));
    @(negedge clk);
    pulse_done(6'b000011, r);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_mac_start", 64'(mac_start), 64'(0));
    chk("midrst_mac_addr", 64'(mac_addr), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    r = '{5, 5, 5, 5, 5, 5};
    pulse_done('1, r);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) quiet++;
      @(negedge clk);
    end
    chk("late_done_ignored", 64'(quiet), 64'(0));
    chk("late_done_in_ready", 64'(in_ready), 64'(1));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
